// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the two-master data bus arbiter:
//   - default address-map constants (RAM page, UART page, debug LED register)
//   - slave-select enum produced by the address decoder and carried down the
//     response pipeline
// -----------------------------------------------------------------------------
package dbus_pkg;

    localparam logic [15:0] RAM_PAGE_DEF  = 16'h0000;
    localparam logic [15:0] UART_PAGE_DEF = 16'hE000;
    localparam logic [31:0] DBG_ADDR_DEF  = 32'hF000_0000;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_UART = 2'd2,
        SEL_DBG  = 2'd3
    } sel_e;

endpackage

// File: rtl/dbus_decode.sv
// -----------------------------------------------------------------------------
// dbus_decode
// Combinational address decoder for the data bus.
// Ports:
//   addr_i  32-bit byte address of the access being issued
//   sel_o   selected slave (SEL_NONE when the address is unmapped)
// The debug register is an exact-address match and wins over the page
// matches, so it may live inside either page without being shadowed.
// -----------------------------------------------------------------------------
module dbus_decode
    import dbus_pkg::*;
#(
    parameter logic [15:0] RAM_PAGE  = RAM_PAGE_DEF,
    parameter logic [15:0] UART_PAGE = UART_PAGE_DEF,
    parameter logic [31:0] DBG_ADDR  = DBG_ADDR_DEF
) (
    input  logic [31:0] addr_i,
    output sel_e        sel_o
);

    always_comb begin
        sel_o = SEL_NONE;
        if (addr_i == DBG_ADDR) begin
            sel_o = SEL_DBG;
        end else if (addr_i[31:16] == UART_PAGE) begin
            sel_o = SEL_UART;
        end else if (addr_i[31:16] == RAM_PAGE) begin
            sel_o = SEL_RAM;
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// -----------------------------------------------------------------------------
// dbus_arbiter
// Round-robin arbiter between two bus masters (m0 = CPU, m1 = loader/DMA)
// sharing one slave bus with three slaves: synchronous RAM, UART, debug LED.
// One access may be issued per cycle; read responses return exactly one
// cycle after the grant, in grant order.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   mN_req/addr/we/wdata          master N request (held until granted)
//   mN_gnt                        access issued this cycle (combinational)
//   mN_rvalid/rdata/err           response one cycle after grant
//   s_addr/s_wdata/s_we           shared slave bus (winner's values)
//   cs_ram/cs_uart/cs_dbg         one-hot chip selects
//   ram_rdata                     RAM q, valid the cycle after the address
//   uart_rdata                    combinational UART status/data byte
// -----------------------------------------------------------------------------
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter logic [15:0] RAM_PAGE  = RAM_PAGE_DEF,
    parameter logic [15:0] UART_PAGE = UART_PAGE_DEF,
    parameter logic [31:0] DBG_ADDR  = DBG_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic        s_we,
    output logic        cs_ram,
    output logic        cs_uart,
    output logic        cs_dbg,

    input  logic [31:0] ram_rdata,
    input  logic [7:0]  uart_rdata
);

    // Round-robin pointer: id of the master granted last. Reset value 1 so
    // master 0 wins the first contention.
    logic        last_q, last_d;

    // Response pipeline (one stage): valid access, its master, slave, read flag
    logic        vld_q, vld_d;
    logic        mid_q;
    sel_e        sel_q;
    logic        rd_q;
    logic [7:0]  uart_q;

    logic        any_gnt;
    logic        win_id;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_we;
    sel_e        win_sel;

    // Grant: a lone requester wins; on contention the master not granted
    // last wins. Gating with reset_n keeps the bus quiet while in reset.
    always_comb begin
        m0_gnt    = reset_n & m0_req & (~m1_req |  last_q);
        m1_gnt    = reset_n & m1_req & (~m0_req | ~last_q);
        any_gnt   = m0_gnt | m1_gnt;
        win_id    = m1_gnt;
        win_addr  = m1_gnt ? m1_addr  : m0_addr;
        win_wdata = m1_gnt ? m1_wdata : m0_wdata;
        win_we    = m1_gnt ? m1_we    : m0_we;
    end

    dbus_decode #(
        .RAM_PAGE  (RAM_PAGE),
        .UART_PAGE (UART_PAGE),
        .DBG_ADDR  (DBG_ADDR)
    ) u_decode (
        .addr_i (win_addr),
        .sel_o  (win_sel)
    );

    // Slave bus: driven only in a grant cycle; unmapped accesses select
    // nothing and never strobe a write.
    always_comb begin
        s_addr  = any_gnt ? win_addr  : 32'h0;
        s_wdata = any_gnt ? win_wdata : 32'h0;
        cs_ram  = any_gnt & (win_sel == SEL_RAM);
        cs_uart = any_gnt & (win_sel == SEL_UART);
        cs_dbg  = any_gnt & (win_sel == SEL_DBG);
        s_we    = any_gnt & win_we & (win_sel != SEL_NONE);
    end

    always_comb begin
        last_d = any_gnt ? win_id : last_q;
        vld_d  = any_gnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
            vld_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            vld_q  <= vld_d;
        end
    end

    // Payload of the response stage; only meaningful while vld_q is set.
    always_ff @(posedge clk) begin
        if (any_gnt) begin
            mid_q  <= win_id;
            sel_q  <= win_sel;
            rd_q   <= ~win_we;
            uart_q <= uart_rdata;
        end
    end

    // ---- response stage (grant + 1) ----
    logic        rsp_rd;
    logic        rsp_err;
    logic [31:0] rsp_data;

    always_comb begin
        rsp_rd  = vld_q & rd_q;
        rsp_err = vld_q & (sel_q == SEL_NONE);
        case (sel_q)
            SEL_RAM:  rsp_data = ram_rdata;
            SEL_UART: rsp_data = {24'h0, uart_q};
            default:  rsp_data = 32'h0;
        endcase

        m0_rvalid = rsp_rd & ~mid_q;
        m1_rvalid = rsp_rd &  mid_q;
        m0_err    = rsp_err & ~mid_q;
        m1_err    = rsp_err &  mid_q;
        m0_rdata  = m0_rvalid ? rsp_data : 32'h0;
        m1_rdata  = m1_rvalid ? rsp_data : 32'h0;
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: a table of per-cycle vectors followed by
// hand-written sequences for continuous contention and reset mid-transaction.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] s_addr, s_wdata;
    logic        s_we, cs_ram, cs_uart, cs_dbg;
    logic [31:0] ram_rdata;
    logic [7:0]  uart_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbus_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_we      (m0_we),
        .m0_wdata   (m0_wdata),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m0_err     (m0_err),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_we      (m1_we),
        .m1_wdata   (m1_wdata),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .m1_err     (m1_err),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_we       (s_we),
        .cs_ram     (cs_ram),
        .cs_uart    (cs_uart),
        .cs_dbg     (cs_dbg),
        .ram_rdata  (ram_rdata),
        .uart_rdata (uart_rdata)
    );

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        w0;
        logic        r1;
        logic [31:0] a1;
        logic        w1;
        logic [31:0] ram;
        logic [7:0]  uart;
        logic [1:0]  gnt;    // {m1,m0}
        logic [2:0]  cs;     // {dbg,uart,ram}
        logic        swe;
        logic [31:0] saddr;
        logic [1:0]  rv;     // {m1,m0}
        logic [1:0]  err;    // {m1,m0}
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    localparam int NV = 20;
    vec_t v[NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic [31:0] a0, input logic w0, input logic [31:0] wd0,
                         input logic r1, input logic [31:0] a1, input logic w1, input logic [31:0] wd1);
        m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = wd0;
        m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = wd1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " gnt"},   {30'h0, m1_gnt, m0_gnt}, 32'h0);
        chk({tag, " cs"},    {29'h0, cs_dbg, cs_uart, cs_ram}, 32'h0);
        chk({tag, " s_we"},  {31'h0, s_we}, 32'h0);
        chk({tag, " s_addr"}, s_addr, 32'h0);
        chk({tag, " s_wdata"}, s_wdata, 32'h0);
        chk({tag, " rv"},    {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk({tag, " err"},   {30'h0, m1_err, m0_err}, 32'h0);
        chk({tag, " rd0"},   m0_rdata, 32'h0);
        chk({tag, " rd1"},   m1_rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] wd0, wd1, exp_wd;
        string       t;

        //         r0   a0            w0    r1   a1            w1    ram           uart   gnt    cs      swe   saddr         rv     err    rd0           rd1
        v[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        8'h00, 2'b00, 3'b000, 1'b0, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
        v[1]  = '{1'b1, 32'h10,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        8'h00, 2'b01, 3'b001, 1'b0, 32'h10,       2'b00, 2'b00, 32'h0,        32'h0};
        v[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h12345678, 8'h00, 2'b00, 3'b000, 1'b0, 32'h0,        2'b01, 2'b00, 32'h12345678, 32'h0};
        v[3]  = '{1'b1, 32'h20,       1'b0, 1'b1, 32'hE0000004, 1'b0, 32'h0,        8'h5A, 2'b10, 3'b010, 1'b0, 32'hE0000004, 2'b00, 2'b00, 32'h0,        32'h0};
        v[4]  = '{1'b1, 32'h20,       1'b0, 1'b1, 32'h30,       1'b0, 32'h0BADBEEF, 8'h11, 2'b01, 3'b001, 1'b0, 32'h20,       2'b10, 2'b00, 32'h0,        32'h5A};
        v[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h30,       1'b0, 32'hCAFEF00D, 8'h00, 2'b10, 3'b001, 1'b0, 32'h30,       2'b01, 2'b00, 32'hCAFEF00D, 32'h0};
        v[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hE0000000, 1'b1, 32'h13572468, 8'h00, 2'b10, 3'b010, 1'b1, 32'hE0000000, 2'b10, 2'b00, 32'h0,        32'h13572468};
        v[7]  = '{1'b1, 32'h80000000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        8'h00, 2'b01, 3'b000, 1'b0, 32'h80000000, 2'b00, 2'b00, 32'h0,        32'h0};
        v[8]  = '{1'b1, 32'hF0000000, 1'b1, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF, 8'h00, 2'b01, 3'b100, 1'b1, 32'hF0000000, 2'b01, 2'b01, 32'h0,        32'h0};
        v[9]  = '{1'b1, 32'h4,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        8'h00, 2'b01, 3'b001, 1'b0, 32'h4,        2'b00, 2'b00, 32'h0,        32'h0};
        v[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h12340000, 1'b1, 32'h44444444, 8'h00, 2'b10, 3'b000, 1'b0, 32'h12340000, 2'b01, 2'b00, 32'h44444444, 32'h0};
        v[11] = '{1'b1, 32'hF0000000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        8'h00, 2'b01, 3'b100, 1'b0, 32'hF0000000, 2'b00, 2'b10, 32'h0,        32'h0};
        v[12] = '{1'b1, 32'h8,        1'b0, 1'b1, 32'hC,        1'b0, 32'h99999999, 8'h00, 2'b10, 3'b001, 1'b0, 32'hC,        2'b01, 2'b00, 32'h0,        32'h0};
        v[13] = '{1'b1, 32'h8,        1'b0, 1'b1, 32'h10,       1'b0, 32'h13131313, 8'h00, 2'b01, 3'b001, 1'b0, 32'h8,        2'b10, 2'b00, 32'h0,        32'h13131313};
        v[14] = '{1'b1, 32'h24,       1'b0, 1'b1, 32'h10,       1'b0, 32'h14141414, 8'h00, 2'b10, 3'b001, 1'b0, 32'h10,       2'b01, 2'b00, 32'h14141414, 32'h0};
        v[15] = '{1'b1, 32'h24,       1'b0, 1'b0, 32'h0,        1'b0, 32'h15151515, 8'h00, 2'b01, 3'b001, 1'b0, 32'h24,       2'b10, 2'b00, 32'h0,        32'h15151515};
        v[16] = '{1'b1, 32'h40,       1'b0, 1'b1, 32'h50,       1'b0, 32'h16161616, 8'h00, 2'b10, 3'b001, 1'b0, 32'h50,       2'b01, 2'b00, 32'h16161616, 32'h0};
        v[17] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h17171717, 8'h00, 2'b00, 3'b000, 1'b0, 32'h0,        2'b10, 2'b00, 32'h0,        32'h17171717};
        v[18] = '{1'b1, 32'h60,       1'b0, 1'b1, 32'h70,       1'b0, 32'h0,        8'h00, 2'b01, 3'b001, 1'b0, 32'h60,       2'b00, 2'b00, 32'h0,        32'h0};
        v[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h19191919, 8'h00, 2'b00, 3'b000, 1'b0, 32'h0,        2'b01, 2'b00, 32'h19191919, 32'h0};

        // Reset state, with requests held high to show reset masks the grant
        reset_n    = 1'b0;
        ram_rdata  = 32'hDEADBEEF;
        uart_rdata = 8'h77;
        drive(1'b1, 32'h10, 1'b1, 32'h1111, 1'b1, 32'h20, 1'b1, 32'h2222);
        #12;
        chk_quiet("reset");
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        reset_n = 1'b1;

        // Table-driven vectors; pointer state carries from row to row
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            wd0 = 32'hD0D0_0000 | i;
            wd1 = 32'hD1D1_0000 | i;
            drive(v[i].r0, v[i].a0, v[i].w0, wd0, v[i].r1, v[i].a1, v[i].w1, wd1);
            ram_rdata  = v[i].ram;
            uart_rdata = v[i].uart;
            exp_wd = (v[i].gnt == 2'b01) ? wd0 : (v[i].gnt == 2'b10) ? wd1 : 32'h0;
            #3;
            t = $sformatf("v%0d", i);
            chk({t, " gnt"},     {30'h0, m1_gnt, m0_gnt}, {30'h0, v[i].gnt});
            chk({t, " cs"},      {29'h0, cs_dbg, cs_uart, cs_ram}, {29'h0, v[i].cs});
            chk({t, " s_we"},    {31'h0, s_we}, {31'h0, v[i].swe});
            chk({t, " s_addr"},  s_addr, v[i].saddr);
            chk({t, " s_wdata"}, s_wdata, exp_wd);
            chk({t, " rv"},      {30'h0, m1_rvalid, m0_rvalid}, {30'h0, v[i].rv});
            chk({t, " err"},     {30'h0, m1_err, m0_err}, {30'h0, v[i].err});
            chk({t, " rd0"},     m0_rdata, v[i].rd0);
            chk({t, " rd1"},     m1_rdata, v[i].rd1);
        end

        // Continuous contention from reset: strict alternation starting at m0
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0);
        ram_rdata = 32'hABCD0000;
        #3;
        chk("alt reset gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        #2;
        chk("alt c0 gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        chk("alt c0 rv",  {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #3;
            t = $sformatf("alt c%0d", k);
            chk({t, " gnt"}, {30'h0, m1_gnt, m0_gnt}, (k % 2 == 1) ? 32'h2 : 32'h1);
            chk({t, " rv"},  {30'h0, m1_rvalid, m0_rvalid}, (k % 2 == 1) ? 32'h1 : 32'h2);
        end

        // Reset lands while m0's read is outstanding (pointer currently says m0 last)
        @(posedge clk); #1;
        drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("rst-mid grant", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0);
        #2;
        chk_quiet("rst-mid");
        @(posedge clk); #1;
        reset_n = 1'b1;
        #2;
        chk("rst-mid rv after", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk("rst-mid first gnt", {30'h0, m1_gnt, m0_gnt}, 32'h1);
        chk("rst-mid s_addr", s_addr, 32'h400);
        @(posedge clk); #3;
        chk("rst-mid next gnt", {30'h0, m1_gnt, m0_gnt}, 32'h2);
        chk("rst-mid next rv", {30'h0, m1_rvalid, m0_rvalid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
